// File: rtl/bpu_update_queue.sv
// Program-order buffer between the two-lane commit path and the single-record
// BPU update port. Overflowing records are dropped (never stall commit) and counted.
module bpu_update_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic [1:0]              in_valid_i,
    input  logic [2*DATA_W-1:0]     in_data_i,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    input  logic                    out_ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    drop_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             drop_reg, drop_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic [1:0]        nv, na, nd;
    logic [CW-1:0]     free;
    logic              deq;
    logic [AW-1:0]     wr_ptr_inc;
    logic [DATA_W-1:0] lane0, lane1, first_rec;
    logic [CNT_W:0]    drop_sum;

    assign lane0 = in_data_i[DATA_W-1:0];
    assign lane1 = in_data_i[2*DATA_W-1:DATA_W];

    // Compaction: the oldest valid lane always lands at wr_ptr.
    assign first_rec  = in_valid_i[0] ? lane0 : lane1;
    assign wr_ptr_inc = wr_ptr_reg + AW'(1);

    assign out_valid_o = (count_reg != '0);
    assign deq         = out_valid_o & out_ready_i;

    // Space is judged on the registered count; a same-cycle pop does not help.
    assign free = CW'(DEPTH) - count_reg;
    assign nv   = {1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]};
    assign na   = (free >= CW'(nv)) ? nv : free[1:0];
    assign nd   = nv - na;

    assign drop_sum = {1'b0, drop_cnt_reg} + {{(CNT_W-1){1'b0}}, nd};

    always_comb begin
        rd_ptr_next   = rd_ptr_reg + AW'(deq);
        wr_ptr_next   = wr_ptr_reg + AW'(na);
        count_next    = count_reg + CW'(na) - CW'(deq);
        drop_next     = (nd != 2'd0);
        drop_cnt_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clr_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            drop_reg     <= drop_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Storage has no reset; entries are only observable once counted as valid.
    always_ff @(posedge clk) begin
        if (rst_n && !clr_i) begin
            if (na != 2'd0)
                mem[wr_ptr_reg] <= first_rec;
            if (na == 2'd2)
                mem[wr_ptr_inc] <= lane1;
        end
    end

    assign out_data_o = mem[rd_ptr_reg];
    assign count_o    = count_reg;
    assign drop_o     = drop_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_bpu_update_queue.sv
// Scoreboard bench for bpu_update_queue: a reference queue is updated on every
// driven cycle and each test task compares the DUT against it inline.
module tb_bpu_update_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr_i;
    logic [1:0]             in_valid_i;
    logic [2*DATA_W-1:0]    in_data_i;
    logic                   out_valid_o;
    logic [DATA_W-1:0]      out_data_o;
    logic                   out_ready_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   drop_o;
    logic [CNT_W-1:0]       drop_cnt_o;

    bpu_update_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .count_o(count_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb[$];
    int m_dcnt = 0;
    bit m_drop = 1'b0;
    int m_acc  = 0;

    function automatic logic [DATA_W-1:0] tagdata(input int tag);
        logic [31:0] t;
        t = tag;
        return {t, ~t, t ^ 32'h5a5a_a5a5, ~t ^ 32'h1234_5678};
    endfunction

    // Drives one cycle, advances the reference model across the clock edge,
    // then returns inputs to idle #1 after the edge.
    task automatic apply(input logic [1:0] v, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic rdy, input logic clr);
        int  free, nv, na, nd;
        bit  deq;
        in_valid_i  = v;
        in_data_i   = {b, a};
        out_ready_i = rdy;
        clr_i       = clr;
        free = DEPTH - sb.size();
        deq  = rdy && (sb.size() != 0);
        @(posedge clk);
        if (clr) begin
            sb.delete();
            m_drop = 1'b0;
        end else begin
            if (deq) void'(sb.pop_front());
            nv = int'(v[0]) + int'(v[1]);
            na = (nv < free) ? nv : free;
            if (na >= 1) sb.push_back(v[0] ? a : b);
            if (na == 2) sb.push_back(b);
            m_acc += na;
            nd = nv - na;
            m_drop = (nd != 0);
            m_dcnt = (m_dcnt + nd > MAXC) ? MAXC : m_dcnt + nd;
        end
        #1;
        $display("txn v=%b rdy=%b clr=%b -> count=%0d valid=%b drop=%b drop_cnt=%0d",
                 v, rdy, clr, count_o, out_valid_o, drop_o, drop_cnt_o);
        in_valid_i  = 2'b00;
        out_ready_i = 1'b0;
        clr_i       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_i = 2'b11; in_data_i = '1; out_ready_i = 1'b1; clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid_i = 2'b00; out_ready_i = 1'b0;
        sb.delete(); m_dcnt = 0; m_drop = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        checks++;
        if (count_o !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++;
        if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop_o); end
        checks++;
        if (drop_cnt_o !== '0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt_o); end
    endtask

    task automatic test_pair();
        logic [DATA_W-1:0] da, db;
        da = tagdata(32'hA0); db = tagdata(32'hB0);
        apply(2'b11, da, db, 1'b1, 1'b0);
        checks++;
        if (out_data_o !== da || count_o !== 2) begin errors++;
            $display("FAIL pair_first got data=%h count=%0d want data=%h count=2", out_data_o, count_o, da); end
        apply(2'b00, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_data_o !== db || count_o !== 1) begin errors++;
            $display("FAIL pair_second got data=%h count=%0d want data=%h count=1", out_data_o, count_o, db); end
        apply(2'b00, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count_o !== 0 || out_valid_o !== 1'b0) begin errors++;
            $display("FAIL pair_empty got count=%0d valid=%b want 0/0", count_o, out_valid_o); end
    endtask

    task automatic test_compaction();
        logic [DATA_W-1:0] dc;
        dc = tagdata(32'hC0);
        apply(2'b10, tagdata(32'hDEAD), dc, 1'b0, 1'b0);
        checks++;
        if (out_data_o !== dc || count_o !== 1 || out_valid_o !== 1'b1) begin errors++;
            $display("FAIL compaction got data=%h count=%0d want data=%h count=1", out_data_o, count_o, dc); end
        apply(2'b00, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count_o !== 0) begin errors++; $display("FAIL compaction_drain got %0d want 0", count_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++)
            apply(2'b11, tagdata(100 + 2*i), tagdata(101 + 2*i), 1'b0, 1'b0);
        checks++;
        if (count_o !== DEPTH) begin errors++; $display("FAIL ovf_full got %0d want %0d", count_o, DEPTH); end
        apply(2'b11, tagdata(200), tagdata(201), 1'b0, 1'b0);
        checks++;
        if (count_o !== DEPTH || drop_o !== 1'b1 || drop_cnt_o !== 2) begin errors++;
            $display("FAIL ovf_drop2 got count=%0d drop=%b cnt=%0d want %0d/1/2", count_o, drop_o, drop_cnt_o, DEPTH); end
        apply(2'b00, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count_o !== DEPTH - 1 || drop_o !== 1'b0) begin errors++;
            $display("FAIL ovf_deq got count=%0d drop=%b want %0d/0", count_o, drop_o, DEPTH - 1); end
        checks++;
        if (out_data_o !== sb[0]) begin errors++;
            $display("FAIL ovf_head got %h want %h", out_data_o, sb[0]); end
        apply(2'b11, tagdata(300), tagdata(301), 1'b1, 1'b0);
        checks++;
        if (count_o !== DEPTH - 1 || drop_o !== 1'b1 || drop_cnt_o !== 3) begin errors++;
            $display("FAIL ovf_one_free got count=%0d drop=%b cnt=%0d want %0d/1/3", count_o, drop_o, drop_cnt_o, DEPTH - 1); end
        // Drain and confirm lane0 of the last pair was kept and lane1 dropped.
        for (int i = 0; i < 2*DEPTH && sb.size() != 0; i++) begin
            checks++;
            if (out_data_o !== sb[0]) begin errors++;
                $display("FAIL ovf_order got %h want %h", out_data_o, sb[0]); end
            apply(2'b00, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (count_o !== 0 || drop_cnt_o !== m_dcnt[CNT_W-1:0]) begin errors++;
            $display("FAIL ovf_final got count=%0d cnt=%0d want 0/%0d", count_o, drop_cnt_o, m_dcnt); end
    endtask

    task automatic test_wrap_order();
        int  tag, cyc;
        logic [1:0] v;
        logic rdy;
        tag = 1000; cyc = 0; m_acc = 0;
        while (m_acc < 40 && cyc < 600) begin
            v   = 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 3) != 0);
            checks++;
            if (out_valid_o !== (sb.size() != 0) || count_o !== sb.size()) begin errors++;
                $display("FAIL wrap_state got valid=%b count=%0d want %b/%0d", out_valid_o, count_o, sb.size() != 0, sb.size()); end
            if (rdy && sb.size() != 0) begin
                checks++;
                if (out_data_o !== sb[0]) begin errors++;
                    $display("FAIL wrap_order got %h want %h", out_data_o, sb[0]); end
            end
            apply(v, tagdata(tag), tagdata(tag + int'(v[0])), rdy, 1'b0);
            tag += int'(v[0]) + int'(v[1]);
            cyc++;
        end
        checks++;
        if (m_acc < 40) begin errors++; $display("FAIL wrap_budget got %0d accepted want 40", m_acc); end
        cyc = 0;
        while (sb.size() != 0 && cyc < 4*DEPTH) begin
            checks++;
            if (out_data_o !== sb[0]) begin errors++;
                $display("FAIL wrap_drain got %h want %h", out_data_o, sb[0]); end
            apply(2'b00, '0, '0, 1'b1, 1'b0);
            cyc++;
        end
        checks++;
        if (count_o !== 0 || out_valid_o !== 1'b0) begin errors++;
            $display("FAIL wrap_empty got count=%0d valid=%b want 0/0", count_o, out_valid_o); end
        checks++;
        if (drop_cnt_o !== m_dcnt[CNT_W-1:0]) begin errors++;
            $display("FAIL wrap_drop_cnt got %0d want %0d", drop_cnt_o, m_dcnt); end
    endtask

    task automatic test_clear();
        int saved;
        apply(2'b11, tagdata(1), tagdata(2), 1'b0, 1'b0);
        apply(2'b11, tagdata(3), tagdata(4), 1'b0, 1'b0);
        apply(2'b01, tagdata(5), tagdata(6), 1'b0, 1'b0);
        checks++;
        if (count_o !== 5) begin errors++; $display("FAIL clr_pre got %0d want 5", count_o); end
        saved = m_dcnt;
        apply(2'b11, tagdata(7), tagdata(8), 1'b1, 1'b1);
        checks++;
        if (count_o !== 0 || out_valid_o !== 1'b0 || drop_o !== 1'b0) begin errors++;
            $display("FAIL clr_state got count=%0d valid=%b drop=%b want 0/0/0", count_o, out_valid_o, drop_o); end
        checks++;
        if (drop_cnt_o !== saved[CNT_W-1:0]) begin errors++;
            $display("FAIL clr_keep_cnt got %0d want %0d", drop_cnt_o, saved); end
        apply(2'b01, tagdata(9), tagdata(10), 1'b0, 1'b0);
        checks++;
        if (out_data_o !== tagdata(9) || count_o !== 1) begin errors++;
            $display("FAIL clr_restart got data=%h count=%0d want %h/1", out_data_o, count_o, tagdata(9)); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < DEPTH; i++)
            if (sb.size() < DEPTH) apply(2'b01, tagdata(50 + i), '0, 1'b0, 1'b0);
        for (int i = 0; i < 4*MAXC && m_dcnt < MAXC - 1; i++)
            apply((m_dcnt == MAXC - 2) ? 2'b01 : 2'b11, tagdata(60), tagdata(61), 1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== MAXC - 1) begin errors++;
            $display("FAIL sat_pre got %0d want %0d", drop_cnt_o, MAXC - 1); end
        apply(2'b11, tagdata(70), tagdata(71), 1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== MAXC || drop_o !== 1'b1) begin errors++;
            $display("FAIL sat_hit got cnt=%0d drop=%b want %0d/1", drop_cnt_o, drop_o, MAXC); end
        apply(2'b11, tagdata(72), tagdata(73), 1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== MAXC || count_o !== DEPTH) begin errors++;
            $display("FAIL sat_hold got cnt=%0d count=%0d want %0d/%0d", drop_cnt_o, count_o, MAXC, DEPTH); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_compaction();
        test_overflow();
        test_wrap_order();
        test_clear();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
